// File: rtl/pio_led_arbiter.sv
//------------------------------------------------------------------------------
// Module  : pio_led_arbiter
// Brief   : Round-robin arbiter sharing one LED PIO Avalon-MM slave between
//           NUM_REQ requesters; one single-cycle bus access per granted command.
//           Optional macro PIO_LED_ARB_PRIO0_EN gives requester 0 fixed priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pio_led_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DW      = 4,
   parameter int IDX_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [2*NUM_REQ-1:0]  op,
   input  logic [DW*NUM_REQ-1:0] wdata,
   output logic [NUM_REQ-1:0]    ack,
   output logic [DW-1:0]         rdata,
   output logic [IDX_W-1:0]      grant_id,
   output logic                  busy,
   output logic [2:0]            avm_address,
   output logic                  avm_chipselect,
   output logic                  avm_write_n,
   output logic [31:0]           avm_writedata,
   input  logic [31:0]           avm_readdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0]         c_OP_RD   = 2'b00;
   localparam logic [1:0]         c_OP_WR   = 2'b01;
   localparam logic [1:0]         c_OP_SET  = 2'b10;
   localparam logic [1:0]         c_OP_CLR  = 2'b11;
   localparam logic [IDX_W:0]     c_NREQ    = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0]   c_LAST    = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] c_ACK_ONE = NUM_REQ'(1);

   state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_ptr, w_ptr_nxt;
   logic [1:0]          r_op, w_op_nxt;
   logic [IDX_W-1:0]    r_grant_id, w_gid_nxt;
   logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
   logic [DW-1:0]       r_rdata, w_rdata_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_cs, w_cs_nxt;
   logic                r_wn, w_wn_nxt;
   logic [2:0]          r_addr, w_addr_nxt;
   logic [31:0]         r_wdo, w_wdo_nxt;

   logic [2*NUM_REQ-1:0] w_req_dbl;
   logic [NUM_REQ-1:0]   w_req_rot;
   logic [IDX_W-1:0]     w_off;
   logic [IDX_W:0]       w_sum;
   logic [IDX_W-1:0]     w_rr_win;
   logic                 w_prio0;
   logic [IDX_W-1:0]     w_win;
   logic [1:0]           w_win_op;
   logic [DW-1:0]        w_win_wd;
   logic [2:0]           w_win_addr;

   // Rotate requests so that bit 0 is the requester the pointer names.
   assign w_req_dbl = {req, req} >> r_ptr;
   assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

   always_comb begin
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_off = IDX_W'(k);
         end
      end
   end

   assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_rr_win = (w_sum >= c_NREQ) ? IDX_W'(w_sum - c_NREQ) : w_sum[IDX_W-1:0];

`ifdef PIO_LED_ARB_PRIO0_EN
   assign w_prio0 = req[0];
`else
   assign w_prio0 = 1'b0;
`endif

   assign w_win = w_prio0 ? '0 : w_rr_win;

   always_comb begin
      w_win_op = c_OP_RD;
      w_win_wd = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_win == IDX_W'(k)) begin
            w_win_op = op[2*k +: 2];
            w_win_wd = wdata[DW*k +: DW];
         end
      end
   end

   always_comb begin
      w_win_addr = 3'd0;
      case (w_win_op)
         c_OP_SET: w_win_addr = 3'd4;
         c_OP_CLR: w_win_addr = 3'd5;
         default:  w_win_addr = 3'd0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_op_nxt    = r_op;
      w_gid_nxt   = r_grant_id;
      w_ack_nxt   = '0;
      w_rdata_nxt = r_rdata;
      w_busy_nxt  = 1'b0;
      w_cs_nxt    = 1'b0;
      w_wn_nxt    = 1'b1;
      w_addr_nxt  = r_addr;
      w_wdo_nxt   = r_wdo;
      unique case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_state_nxt = S_XFER;
               w_gid_nxt   = w_win;
               w_op_nxt    = w_win_op;
               w_busy_nxt  = 1'b1;
               w_cs_nxt    = 1'b1;
               w_wn_nxt    = (w_win_op == c_OP_RD);
               w_addr_nxt  = w_win_addr;
               w_wdo_nxt   = 32'(w_win_wd);
               if (!w_prio0) begin
                  w_ptr_nxt = (w_win == c_LAST) ? '0 : w_win + IDX_W'(1);
               end
            end
         end
         S_XFER: begin
            // Slave returns data combinationally, so capture in the access cycle.
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b1;
            w_ack_nxt   = c_ACK_ONE << r_grant_id;
            if (r_op == c_OP_RD) begin
               w_rdata_nxt = avm_readdata[DW-1:0];
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_op       <= c_OP_RD;
         r_grant_id <= '0;
         r_ack      <= '0;
         r_rdata    <= '0;
         r_busy     <= 1'b0;
         r_cs       <= 1'b0;
         r_wn       <= 1'b1;
         r_addr     <= 3'd0;
         r_wdo      <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_ptr      <= w_ptr_nxt;
         r_op       <= w_op_nxt;
         r_grant_id <= w_gid_nxt;
         r_ack      <= w_ack_nxt;
         r_rdata    <= w_rdata_nxt;
         r_busy     <= w_busy_nxt;
         r_cs       <= w_cs_nxt;
         r_wn       <= w_wn_nxt;
         r_addr     <= w_addr_nxt;
         r_wdo      <= w_wdo_nxt;
      end
   end

   assign ack            = r_ack;
   assign rdata          = r_rdata;
   assign grant_id       = r_grant_id;
   assign busy           = r_busy;
   assign avm_address    = r_addr;
   assign avm_chipselect = r_cs;
   assign avm_write_n    = r_wn;
   assign avm_writedata  = r_wdo;

   generate
      if (DW < 32) begin : g_rd_unused
         logic w_unused_rd;
         assign w_unused_rd = ^avm_readdata[31:DW];
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pio_led_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_pio_led_arbiter
// Brief   : Directed and randomized bench for pio_led_arbiter with an LED PIO
//           slave model; honours PIO_LED_ARB_PRIO0_EN when defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pio_led_arbiter;

   localparam int N  = 2;
   localparam int DW = 4;
   localparam logic [1:0] RD = 2'b00, WR = 2'b01, SET = 2'b10, CLR = 2'b11;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req   = '0;
   logic [2*N-1:0]    op    = '0;
   logic [DW*N-1:0]   wdata = '0;
   logic [N-1:0]      ack;
   logic [DW-1:0]     rdata;
   logic [0:0]        grant_id;
   logic              busy;
   logic [2:0]        avm_address;
   logic              avm_chipselect;
   logic              avm_write_n;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata;
   logic [3:0]        pio;

   int n_checks = 0;
   int n_pass   = 0;

   pio_led_arbiter #(.NUM_REQ(N), .DW(DW), .IDX_W(1)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
      .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata)
   );

   always #5 clk = ~clk;

   // LED PIO slave: data @0, bit-set @4, bit-clear @5, reset value 4'hF.
   assign avm_readdata = {28'd0, pio};
   always @(posedge clk) begin
      if (reset) pio <= 4'hF;
      else if (avm_chipselect && !avm_write_n) begin
         case (avm_address)
            3'd0:    pio <= avm_writedata[3:0];
            3'd4:    pio <= pio | avm_writedata[3:0];
            3'd5:    pio <= pio & ~avm_writedata[3:0];
            default: ;
         endcase
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [2:0] exp_addr(input logic [1:0] o);
      return (o == SET) ? 3'd4 : (o == CLR) ? 3'd5 : 3'd0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One command from a lone requester; checks the access and the ack cycle.
   task automatic cmd(input int id, input logic [1:0] o, input logic [3:0] wd, input string tag);
      @(negedge clk);
      req = '0;
      req[id] = 1'b1;
      op[2*id +: 2]    = o;
      wdata[4*id +: 4] = wd;
      @(negedge clk);
      check({tag, "_cs"},   32'(avm_chipselect), 32'd1);
      check({tag, "_addr"}, 32'(avm_address), 32'(exp_addr(o)));
      check({tag, "_wn"},   32'(avm_write_n), 32'(o == RD));
      check({tag, "_wd"},   avm_writedata, 32'(wd));
      check({tag, "_busyx"}, 32'(busy), 32'd1);
      check({tag, "_gid"},  32'(grant_id), 32'(id));
      @(negedge clk);
      check({tag, "_ack"},  32'(ack), 32'(1 << id));
      check({tag, "_busyd"}, 32'(busy), 32'd1);
      check({tag, "_csd"},  32'(avm_chipselect), 32'd0);
      req[id] = 1'b0;
   endtask

   // Reference model state for the randomized phase.
   int         m_stage;
   int         m_ptr;
   int         m_win;
   logic [1:0] m_op;
   logic [3:0] m_wd;
   logic [3:0] m_rd_val;
   logic [3:0] m_exp_rdata;
   bit         pend [N];

   task automatic rand_step();
      logic [N-1:0] r_edge;
      int           done_id;
      @(negedge clk);
      r_edge  = req;
      done_id = -1;
      case (m_stage)
         0: if (r_edge != '0) begin
`ifdef PIO_LED_ARB_PRIO0_EN
               if (r_edge[0]) m_win = 0;
               else begin
                  for (int k = 0; k < N; k++) begin
                     if (r_edge[(m_ptr + k) % N]) begin m_win = (m_ptr + k) % N; break; end
                  end
                  m_ptr = (m_win + 1) % N;
               end
`else
               for (int k = 0; k < N; k++) begin
                  if (r_edge[(m_ptr + k) % N]) begin m_win = (m_ptr + k) % N; break; end
               end
               m_ptr = (m_win + 1) % N;
`endif
               m_op     = op[2*m_win +: 2];
               m_wd     = wdata[4*m_win +: 4];
               m_rd_val = pio;
               m_stage  = 1;
            end
         1: m_stage = 2;
         default: m_stage = 0;
      endcase

      case (m_stage)
         1: begin
            check("r_cs",   32'(avm_chipselect), 32'd1);
            check("r_addr", 32'(avm_address), 32'(exp_addr(m_op)));
            check("r_wn",   32'(avm_write_n), 32'(m_op == RD));
            check("r_wd",   avm_writedata, 32'(m_wd));
            check("r_busy", 32'(busy), 32'd1);
            check("r_ack",  32'(ack), 32'd0);
         end
         2: begin
            if (m_op == RD) m_exp_rdata = m_rd_val;
            check("r_cs",   32'(avm_chipselect), 32'd0);
            check("r_wn",   32'(avm_write_n), 32'd1);
            check("r_busy", 32'(busy), 32'd1);
            check("r_ack",  32'(ack), 32'(1 << m_win));
            done_id = m_win;
         end
         default: begin
            check("r_cs",   32'(avm_chipselect), 32'd0);
            check("r_busy", 32'(busy), 32'd0);
            check("r_ack",  32'(ack), 32'd0);
         end
      endcase
      check("r_gid",   32'(grant_id), 32'(m_win));
      check("r_rdata", 32'(rdata), 32'(m_exp_rdata));

      // Drive the next cycle's requests.
      if (done_id >= 0) begin
         pend[done_id] = 1'b0;
         req[done_id]  = 1'b0;
      end
      if (m_stage == 1 && $urandom_range(0, 3) == 0) begin
         wdata[4*m_win +: 4] = 4'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            pend[m_win] = 1'b0;
            req[m_win]  = 1'b0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && i != done_id && !(m_stage == 1 && i == m_win)) begin
            if ($urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               req[i]  = 1'b1;
               op[2*i +: 2]    = 2'($urandom);
               wdata[4*i +: 4] = 4'($urandom);
            end
         end else if (pend[i] && m_stage == 0 && $urandom_range(0, 19) == 0) begin
            pend[i] = 1'b0;
            req[i]  = 1'b0;
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ack",  32'(ack), 32'd0);
      check("rst_rd",   32'(rdata), 32'd0);
      check("rst_gid",  32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cs",   32'(avm_chipselect), 32'd0);
      check("rst_wn",   32'(avm_write_n), 32'd1);
      check("rst_addr", 32'(avm_address), 32'd0);
      check("rst_wd",   avm_writedata, 32'd0);
      reset = 1'b0;

      // Single write, busy for exactly two cycles
      cmd(0, WR, 4'hA, "t1");
      @(negedge clk);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_ack_end",  32'(ack), 32'd0);
      check("t1_pio",      32'(pio), 32'hA);

      // Set / clear against the PIO reset value
      do_reset();
      cmd(1, SET, 4'h3, "t2s");
      cmd(1, CLR, 4'h1, "t2c");
      @(negedge clk);
      check("t2_pio", 32'(pio), 32'hE);

      // Read captures slave data, later write leaves it alone
      cmd(0, WR, 4'h5, "t3w");
      cmd(0, RD, 4'h0, "t3r");
      check("t3_rdata", 32'(rdata), 32'h5);
      cmd(0, WR, 4'h7, "t3w2");
      check("t3_rdata_hold", 32'(rdata), 32'h5);

      // Both requesters held continuously
      do_reset();
      @(negedge clk);
      req   = 2'b11;
      op    = {WR, WR};
      wdata = {4'h2, 4'h1};
      for (int g = 0; g < 4; g++) begin
         int eg;
`ifdef PIO_LED_ARB_PRIO0_EN
         eg = 0;
`else
         eg = g % 2;
`endif
         @(negedge clk);
         check("t4_cs",  32'(avm_chipselect), 32'd1);
         check("t4_gid", 32'(grant_id), 32'(eg));
         check("t4_wd",  avm_writedata, 32'(eg + 1));
         @(negedge clk);
         check("t4_ack", 32'(ack), 32'(1 << eg));
         @(negedge clk);
         check("t4_idle", 32'(avm_chipselect), 32'd0);
      end
      req = '0;

      // Reset during an access aborts it
      do_reset();
      @(negedge clk);
      req = 2'b10;
      op[3:2] = WR;
      wdata[7:4] = 4'h6;
      @(negedge clk);
      check("t5_cs",  32'(avm_chipselect), 32'd1);
      check("t5_gid", 32'(grant_id), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t5_cs_off", 32'(avm_chipselect), 32'd0);
      check("t5_wn",     32'(avm_write_n), 32'd1);
      check("t5_ack",    32'(ack), 32'd0);
      check("t5_busy",   32'(busy), 32'd0);
      check("t5_gid0",   32'(grant_id), 32'd0);
      reset = 1'b0;
      req   = '0;
      @(negedge clk);
      check("t5_ack_late", 32'(ack), 32'd0);
      check("t5_idle",     32'(busy), 32'd0);

      // Command is latched at grant
      @(negedge clk);
      req = 2'b01;
      op[1:0] = WR;
      wdata[3:0] = 4'h9;
      @(negedge clk);
      check("t6_wd", avm_writedata, 32'h9);
      req = '0;
      wdata[3:0] = 4'hF;
      @(negedge clk);
      check("t6_ack", 32'(ack), 32'd1);
      check("t6_pio", 32'(pio), 32'h9);

      // Request withdrawn before any grant edge issues nothing
      @(negedge clk);
      req = 2'b01;
      #2 req = '0;
      @(negedge clk);
      check("t7_cs",   32'(avm_chipselect), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);

      // Randomized traffic against the model
      do_reset();
      m_stage = 0;
      m_ptr   = 0;
      m_win   = 0;
      m_op    = RD;
      m_wd    = '0;
      m_rd_val    = '0;
      m_exp_rdata = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      repeat (900) rand_step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
